recv_rr_sched: RTL and testbench
================================

// Module: recv_rr_sched
// PURPOSE
// Round-robin scheduler that shares one Ethernet frame receiver among NUM_CH byte-stream requesters.
// - Arbitrates pending requests and grants one channel at a time.
// - Muxes the granted channel's octets to the receiver and pulses its start.
// - Watches the receiver until it returns to idle, then classifies the frame and reports status.
// - Resets a hung receiver after a timeout.
// Sits between the PHY-side channel buffers and the single receiver instance.
// PARAMETERS
// NUM_CH          4        number of requester channels (2..16); CHW = $clog2(NUM_CH) (localparam)
// TIMEOUT_CYCLES  16'd2048 max cycles in RUN before the receiver is forcibly reset (>=16)
// PORTS
// clk          in   1           clock
// rst          in   1           reset, synchronous, active-high
// req          in   NUM_CH      req[i]=1: channel i has a frame queued
// ch_data      in   NUM_CH*8    octet stream of channel i at [i*8+:8]
// gnt          out  NUM_CH      one-hot grant; 0 when idle
// busy         out  1           1 from START through DONE
// rx_data      out  8           octet to receiver = ch_data of granted channel, else 8'h00 (combinational)
// rx_start     out  1           one-cycle start pulse to receiver
// rx_rst       out  1           one-cycle receiver reset on timeout
// rx_ready     in   1           receiver idle/ready
// rx_vld       in   1           receiver output valid
// rx_out       in   8           receiver output octet
// done         out  1           one-cycle frame-complete pulse
// done_ch      out  CHW         channel index of completed frame (valid with done)
// done_status  out  2           00 OK, 01 ERROR, 10 FILTERED, 11 TIMEOUT (valid with done)
// BEHAVIOUR
// - Reset: gnt=0, busy=0, rx_start=0, rx_rst=0, done=0, done_ch=0, done_status=0, ptr=0, tcnt=0, state=IDLE.
// - Reset mid-frame aborts the frame. gnt drops the cycle after rst and no done is issued.
// - FSM IDLE -> START: when rx_ready=1 and |req.
//   - Winner is the first i with req[i]=1, scanning from ptr upward and wrapping past NUM_CH-1.
//   - gnt is registered and updates in the START cycle.
// - START (1 cycle): rx_start=1, gnt held, busy=1.
//   - Requester drives its first preamble octet on ch_data in this cycle; later octets follow one per cycle.
//   - Go to RUN.
// - RUN: gnt held regardless of req changes; tcnt increments from 0.
//   - Each cycle, the scheduler registers last_vld=rx_vld and last_out=rx_out.
//   - rx_ready=1 -> DONE.
//     - Status = OK if last_vld and last_out==8'h00.
//     - Status = ERROR if last_vld and last_out[7:4]==4'hF.
//     - Status = FILTERED if !last_vld (dest-MAC miss).
//     - Any other last_out value -> ERROR.
//     - rx_ready=1 on the first RUN cycle -> ERROR (receiver never left idle).
//   - tcnt==TIMEOUT_CYCLES-1 without rx_ready -> rx_rst=1 for one cycle, then DONE with status TIMEOUT.
//     - Timeout takes priority if both occur in the same cycle.
// - DONE (1 cycle): done=1, done_ch/done_status driven.
//   - gnt=0, ptr=(winner+1)%NUM_CH, tcnt=0, back to IDLE.
//   - Earliest next START is 1 cycle after DONE: 2-cycle turnaround, provided rx_ready=1.
// - done_ch and done_status hold their last values between pulses.
// - Requests raised while rx_ready=0 wait in IDLE; no request is ever dropped.
// - A channel whose req falls while waiting is simply skipped.
// CONFIGURATION
// - RECV_SCHED_STATS_EN defined: adds outputs cnt_ok, cnt_err, cnt_drop (16 bits each).
//   - Saturating at 16'hFFFF.
//   - Increment on done with OK, ERROR, and FILTERED-or-TIMEOUT status respectively.
//   - Cleared by rst.
// - RECV_SCHED_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
// 1. req=4'b0001, valid frame to DEST_MAC, correct FCS.
//    -> rx_start one cycle with gnt=4'b0001; done with done_ch=0, status=2'b00.
// 2. req=4'b1111 held, three valid frames back-to-back.
//    -> grants 0001, 0010, 0100 in order; three done pulses with done_ch=0,1,2.
// 3. Channel 2 frame with dest MAC 48'h00_0a_95_9d_68_17.
//    -> done_ch=2, status=2'b10; rx_vld never seen.
// 4. Channel 1 frame with FCS octet off by 1.
//    -> done status=2'b01, done_ch=1; ptr advances to 2.
// 5. TIMEOUT_CYCLES=64, payload length field 16'hFFFF.
//    -> rx_rst pulse on RUN cycle 64; done status=2'b11.
// 6. rst asserted on RUN cycle 10 with req=4'b1000.
//    -> next cycle gnt=0, busy=0, no done pulse; after release, channel 3 is granted again with ptr=0.

Source files
------------

// File: rtl/recv_rr_sched.sv
// Round-robin share of one frame receiver among NUM_CH requesters; optional RECV_SCHED_STATS_EN adds outcome counters.
// Latency: grant/rx_start one cycle after rx_ready&&req; done one cycle after receiver idle (or rx_rst on timeout).
// Backpressure: requests wait in IDLE while rx_ready=0 and are never dropped; grant is held for the whole frame.
module recv_rr_sched #(
    parameter int          NUM_CH         = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd2048,
    localparam int         CHW            = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   req,
    input  logic [NUM_CH*8-1:0] ch_data,
    output logic [NUM_CH-1:0]   gnt,
    output logic                busy,
    output logic [7:0]          rx_data,
    output logic                rx_start,
    output logic                rx_rst,
    input  logic                rx_ready,
    input  logic                rx_vld,
    input  logic [7:0]          rx_out,
    output logic                done,
    output logic [CHW-1:0]      done_ch,
    output logic [1:0]          done_status
`ifdef RECV_SCHED_STATS_EN
    ,
    output logic [15:0]         cnt_ok,
    output logic [15:0]         cnt_err,
    output logic [15:0]         cnt_drop
`endif
);

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_ERROR    = 2'b01;
    localparam logic [1:0] ST_FILTERED = 2'b10;
    localparam logic [1:0] ST_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [CHW-1:0] ptr, win, pick, ptr_inc;
    logic           found;
    logic [15:0]    tcnt;
    logic           last_vld;
    logic [7:0]     last_out;
    logic           tmo;
    logic [1:0]     run_status;

    // First requesting channel at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            logic [CHW-1:0] cand;
            cand = CHW'((int'(ptr) + i) % NUM_CH);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign ptr_inc = (win == CHW'(NUM_CH - 1)) ? '0 : win + CHW'(1);
    assign tmo     = (state == RUN) && (tcnt == TIMEOUT_CYCLES - 16'd1);

    // A receiver that reports ready on the very first RUN cycle never accepted the frame.
    always_comb begin
        run_status = ST_ERROR;
        if (tmo)
            run_status = ST_TIMEOUT;
        else if (tcnt == 16'd0)
            run_status = ST_ERROR;
        else if (!last_vld)
            run_status = ST_FILTERED;
        else if (last_out == 8'h00)
            run_status = ST_OK;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rx_ready && found) state_nxt = START;
            START:   state_nxt = RUN;
            RUN:     if (tmo || rx_ready) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign rx_start = (state == START);
    assign rx_rst   = tmo;
    assign done     = (state == DONE);

    always_comb begin
        rx_data = 8'h00;
        for (int i = 0; i < NUM_CH; i++)
            if (gnt[i]) rx_data = ch_data[i*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= '0;
            win         <= '0;
            ptr         <= '0;
            tcnt        <= '0;
            last_vld    <= 1'b0;
            last_out    <= 8'h00;
            done_ch     <= '0;
            done_status <= ST_OK;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (state_nxt == START) begin
                    win <= pick;
                    gnt <= NUM_CH'(1) << pick;
                end
                START: begin
                    last_vld <= 1'b0;
                    last_out <= 8'h00;
                    tcnt     <= '0;
                end
                RUN: begin
                    last_vld <= rx_vld;
                    last_out <= rx_out;
                    tcnt     <= tcnt + 16'd1;
                    if (state_nxt == DONE) begin
                        gnt         <= '0;
                        done_ch     <= win;
                        done_status <= run_status;
                    end
                end
                DONE: begin
                    ptr  <= ptr_inc;
                    tcnt <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef RECV_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_ok   <= '0;
            cnt_err  <= '0;
            cnt_drop <= '0;
        end else if (done) begin
            case (done_status)
                ST_OK:    if (cnt_ok   != 16'hFFFF) cnt_ok   <= cnt_ok + 16'd1;
                ST_ERROR: if (cnt_err  != 16'hFFFF) cnt_err  <= cnt_err + 16'd1;
                default:  if (cnt_drop != 16'hFFFF) cnt_drop <= cnt_drop + 16'd1;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_recv_rr_sched.sv
// Directed bench for recv_rr_sched: per-cycle vector table plus timeout and mid-frame reset sequences.
module tb_recv_rr_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] ch_data = 32'h44332211;
    logic [3:0]  gnt;
    logic        busy;
    logic [7:0]  rx_data;
    logic        rx_start;
    logic        rx_rst;
    logic        rx_ready = 1'b1;
    logic        rx_vld = 1'b0;
    logic [7:0]  rx_out = 8'h00;
    logic        done;
    logic [1:0]  done_ch;
    logic [1:0]  done_status;

    int total = 0;
    int bad   = 0;

    recv_rr_sched #(.NUM_CH(4), .TIMEOUT_CYCLES(16'd64)) dut (
        .clk(clk), .rst(rst), .req(req), .ch_data(ch_data), .gnt(gnt), .busy(busy),
        .rx_data(rx_data), .rx_start(rx_start), .rx_rst(rx_rst), .rx_ready(rx_ready),
        .rx_vld(rx_vld), .rx_out(rx_out), .done(done), .done_ch(done_ch), .done_status(done_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        rdy;
        logic        vld;
        logic [7:0]  out;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic r, input logic [3:0] q, input logic rd, input logic vl,
                     input logic [7:0] o, input logic [3:0] g, input logic b, input logic s,
                     input logic rr, input logic d, input logic [1:0] dc, input logic [1:0] ds,
                     input logic [7:0] rx);
        vec_t t;
        t.rst = r; t.req = q; t.rdy = rd; t.vld = vl; t.out = o;
        t.exp = {g, b, s, rr, d, dc, ds, rx};
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] outs();
        return {gnt, busy, rx_start, rx_rst, done, done_ch, done_status, rx_data};
    endfunction

    initial begin
        int pre_rst;
        int dn_seen;

        // fields: rst req rdy vld out | gnt busy start rx_rst done done_ch status rx_data
        v(1, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 2'd0, 2'b00, 8'h00);
        // single channel 0, OK frame
        v(0, 4'b0001, 1, 0, 8'h00, 4'b0001, 1, 1, 0, 0, 2'd0, 2'b00, 8'h11);
        v(0, 4'b0001, 0, 0, 8'h00, 4'b0001, 1, 0, 0, 0, 2'd0, 2'b00, 8'h11);
        v(0, 4'b0000, 0, 1, 8'h00, 4'b0001, 1, 0, 0, 0, 2'd0, 2'b00, 8'h11);
        v(0, 4'b0000, 1, 0, 8'h00, 4'b0000, 1, 0, 0, 1, 2'd0, 2'b00, 8'h00);
        v(0, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 2'd0, 2'b00, 8'h00);
        v(1, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 2'd0, 2'b00, 8'h00);
        // all requesting: round robin 0,1,2
        v(0, 4'b1111, 1, 0, 8'h00, 4'b0001, 1, 1, 0, 0, 2'd0, 2'b00, 8'h11);
        v(0, 4'b1111, 0, 0, 8'h00, 4'b0001, 1, 0, 0, 0, 2'd0, 2'b00, 8'h11);
        v(0, 4'b1111, 0, 1, 8'h00, 4'b0001, 1, 0, 0, 0, 2'd0, 2'b00, 8'h11);
        v(0, 4'b1111, 1, 0, 8'h00, 4'b0000, 1, 0, 0, 1, 2'd0, 2'b00, 8'h00);
        v(0, 4'b1111, 1, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 2'd0, 2'b00, 8'h00);
        v(0, 4'b1111, 1, 0, 8'h00, 4'b0010, 1, 1, 0, 0, 2'd0, 2'b00, 8'h22);
        v(0, 4'b1111, 0, 0, 8'h00, 4'b0010, 1, 0, 0, 0, 2'd0, 2'b00, 8'h22);
        v(0, 4'b1111, 0, 1, 8'h00, 4'b0010, 1, 0, 0, 0, 2'd0, 2'b00, 8'h22);
        v(0, 4'b1111, 1, 0, 8'h00, 4'b0000, 1, 0, 0, 1, 2'd1, 2'b00, 8'h00);
        v(0, 4'b1111, 1, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 2'd1, 2'b00, 8'h00);
        v(0, 4'b1111, 1, 0, 8'h00, 4'b0100, 1, 1, 0, 0, 2'd1, 2'b00, 8'h33);
        v(0, 4'b1111, 0, 0, 8'h00, 4'b0100, 1, 0, 0, 0, 2'd1, 2'b00, 8'h33);
        v(0, 4'b1111, 0, 1, 8'h00, 4'b0100, 1, 0, 0, 0, 2'd1, 2'b00, 8'h33);
        v(0, 4'b1111, 1, 0, 8'h00, 4'b0000, 1, 0, 0, 1, 2'd2, 2'b00, 8'h00);
        v(0, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 2'd2, 2'b00, 8'h00);
        // channel 2 filtered (no rx_vld)
        v(0, 4'b0100, 1, 0, 8'h00, 4'b0100, 1, 1, 0, 0, 2'd2, 2'b00, 8'h33);
        v(0, 4'b0100, 0, 0, 8'h00, 4'b0100, 1, 0, 0, 0, 2'd2, 2'b00, 8'h33);
        v(0, 4'b0100, 0, 0, 8'h00, 4'b0100, 1, 0, 0, 0, 2'd2, 2'b00, 8'h33);
        v(0, 4'b0100, 1, 0, 8'h00, 4'b0000, 1, 0, 0, 1, 2'd2, 2'b10, 8'h00);
        v(0, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 2'd2, 2'b10, 8'h00);
        // channel 1 FCS error, then ptr=2 picks ch2 over ch1
        v(0, 4'b0010, 1, 0, 8'h00, 4'b0010, 1, 1, 0, 0, 2'd2, 2'b10, 8'h22);
        v(0, 4'b0010, 0, 0, 8'h00, 4'b0010, 1, 0, 0, 0, 2'd2, 2'b10, 8'h22);
        v(0, 4'b0010, 0, 1, 8'hF1, 4'b0010, 1, 0, 0, 0, 2'd2, 2'b10, 8'h22);
        v(0, 4'b0010, 1, 0, 8'h00, 4'b0000, 1, 0, 0, 1, 2'd1, 2'b01, 8'h00);
        v(0, 4'b0110, 1, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 2'd1, 2'b01, 8'h00);
        v(0, 4'b0110, 1, 0, 8'h00, 4'b0100, 1, 1, 0, 0, 2'd1, 2'b01, 8'h33);
        v(0, 4'b0110, 0, 0, 8'h00, 4'b0100, 1, 0, 0, 0, 2'd1, 2'b01, 8'h33);
        v(0, 4'b0110, 0, 1, 8'h5A, 4'b0100, 1, 0, 0, 0, 2'd1, 2'b01, 8'h33);
        v(0, 4'b0110, 1, 0, 8'h00, 4'b0000, 1, 0, 0, 1, 2'd2, 2'b01, 8'h00);
        v(0, 4'b0010, 1, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 2'd2, 2'b01, 8'h00);
        // ready on first RUN cycle -> error; ptr=3 wraps to ch1
        v(0, 4'b0010, 1, 0, 8'h00, 4'b0010, 1, 1, 0, 0, 2'd2, 2'b01, 8'h22);
        v(0, 4'b0010, 1, 0, 8'h00, 4'b0010, 1, 0, 0, 0, 2'd2, 2'b01, 8'h22);
        v(0, 4'b0010, 1, 0, 8'h00, 4'b0000, 1, 0, 0, 1, 2'd1, 2'b01, 8'h00);
        v(0, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 2'd1, 2'b01, 8'h00);
        // request waits while receiver not ready
        v(0, 4'b1000, 0, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 2'd1, 2'b01, 8'h00);
        v(0, 4'b1000, 0, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 2'd1, 2'b01, 8'h00);
        v(0, 4'b1000, 1, 0, 8'h00, 4'b1000, 1, 1, 0, 0, 2'd1, 2'b01, 8'h44);
        v(0, 4'b1000, 0, 0, 8'h00, 4'b1000, 1, 0, 0, 0, 2'd1, 2'b01, 8'h44);
        v(0, 4'b1000, 0, 1, 8'h00, 4'b1000, 1, 0, 0, 0, 2'd1, 2'b01, 8'h44);
        v(0, 4'b1000, 1, 0, 8'h00, 4'b0000, 1, 0, 0, 1, 2'd3, 2'b00, 8'h00);
        v(0, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 2'd3, 2'b00, 8'h00);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; req = vecs[i].req; rx_ready = vecs[i].rdy;
            rx_vld = vecs[i].vld; rx_out = vecs[i].out;
            step();
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Timeout on RUN cycle 64, with rx_ready arriving in the same cycle.
        req = 4'b0001; rx_ready = 1'b1; rx_vld = 1'b0;
        step();
        chk("to_start", {28'd0, gnt}, 32'h1);
        rx_ready = 1'b0;
        pre_rst = 0;
        for (int k = 1; k <= 64; k++) begin
            step();
            if (k < 64) begin
                if (rx_rst || done) pre_rst++;
            end else begin
                chk("to_rx_rst", {31'd0, rx_rst}, 32'd1);
                rx_ready = 1'b1;
            end
        end
        chk("to_early", 32'(pre_rst), 32'd0);
        req = 4'b0000;
        step();
        chk("to_done", {26'd0, done, rx_rst, gnt, done_ch == 2'd0}, {26'd0, 1'b1, 1'b0, 4'b0000, 1'b1});
        chk("to_status", {30'd0, done_status}, 32'd3);
        step();

        // Reset on RUN cycle 10 aborts the frame without done.
        req = 4'b1000; rx_ready = 1'b1;
        step();
        chk("rs_start", {28'd0, gnt}, 32'h8);
        rx_ready = 1'b0;
        dn_seen = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (done) dn_seen++;
        end
        rst = 1'b1;
        step();
        chk("rs_abort", {29'd0, gnt == 4'b0000, busy, done}, {29'd0, 1'b1, 1'b0, 1'b0});
        rst = 1'b0; rx_ready = 1'b1;
        step();
        if (done) dn_seen++;
        chk("rs_regrant", {26'd0, gnt, rx_start, busy}, {26'd0, 4'b1000, 1'b1, 1'b1});
        chk("rs_no_done", 32'(dn_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
